aes_host_bridge: RTL and testbench

- Host-side master for the AES peripheral's 32-bit bidirectional word bus.
- Accepts a 128-bit key and a 128-bit message in parallel.
- Serializes both onto the bus as four 32-bit write bursts, waits out the cipher latency, then reads the four ciphertext words back.
- Presents the result as one 128-bit word with a done pulse. It sits between the system controller and the AES interface block.

---
 rtl/aes_bridge_pkg.sv | 27 ++
 rtl/aes_host_bridge_if.sv | 27 ++
 rtl/aes_word_serializer.sv | 25 ++
 rtl/aes_host_bridge.sv | 150 +++++++++++++++
 tb/tb_aes_host_bridge.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_bridge_pkg.sv
// Shared types and bus encodings for the AES host bridge and its word serializer.
package aes_bridge_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WK_INIT,
        S_WK_DATA,
        S_WM_INIT,
        S_WM_DATA,
        S_WAIT,
        S_R_INIT,
        S_R_LAT,
        S_R_DATA,
        S_DONE
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam logic ADDR_MSG = 1'b0;
    localparam logic ADDR_KEY = 1'b1;

    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [0:31]  word_t;
    typedef logic [0:127] block_t;

endpackage

// File: rtl/aes_host_bridge_if.sv
// Host request/response signals and AES bus control strobes; data stays a plain inout port.
// Handshake: start is taken only while busy=0 and the bridge is idle; done pulses once with result valid.
interface aes_host_bridge_if;
    import aes_bridge_pkg::*;

    logic   start;
    logic   reuse_key;
    block_t key_in;
    block_t msg_in;
    block_t result;
    logic   done;
    logic   busy;
    logic   RW;
    logic   adress;
    logic   initiate;

    modport master (
        input  start, reuse_key, key_in, msg_in,
        output result, done, busy, RW, adress, initiate
    );

    modport slave (
        output start, reuse_key, key_in, msg_in,
        input  result, done, busy, RW, adress, initiate
    );

endinterface

// File: rtl/aes_word_serializer.sv
// Holds one 128-bit block and presents the 32-bit word picked by idx_i (word 0 = MSBs).
module aes_word_serializer
    import aes_bridge_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  block_t block_i,
    input  logic [1:0] idx_i,
    output word_t  word_o
);

    block_t block_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_q <= '0;
        end else if (load_i) begin
            block_q <= block_i;
        end
    end

    assign word_o = block_q[{idx_i, 5'd0} +: 32];

endmodule

// File: rtl/aes_host_bridge.sv
// Host-side master: writes key and message as 4-word bursts, waits out the cipher,
// then reads the 4 ciphertext words back into a 128-bit result.
module aes_host_bridge
    import aes_bridge_pkg::*;
#(
    parameter int CIPHER_WAIT  = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    aes_host_bridge_if.master host,
    inout  wire  [0:31]       data,
    output state_t            state_o,
    output logic              data_oe_o
);

    localparam int WAIT_W = $clog2(CIPHER_WAIT + 1);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t            state_q, state_d;
    logic [1:0]        word_cnt_q, word_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              key_loaded_q, key_loaded_d;
    block_t            cap_q, cap_d;
    block_t            result_q, result_d;
    logic              key_load, msg_load;
    word_t             key_word, msg_word, wr_word;
    logic              data_oe;

    aes_word_serializer u_key_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (key_load),
        .block_i (host.key_in),
        .idx_i   (word_cnt_q),
        .word_o  (key_word)
    );

    aes_word_serializer u_msg_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (msg_load),
        .block_i (host.msg_in),
        .idx_i   (word_cnt_q),
        .word_o  (msg_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            key_loaded_q <= 1'b0;
            cap_q        <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            key_loaded_q <= key_loaded_d;
            cap_q        <= cap_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        key_loaded_d = key_loaded_q;
        cap_d        = cap_q;
        result_d     = result_q;
        key_load     = 1'b0;
        msg_load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    msg_load = 1'b1;
                    if (host.reuse_key && key_loaded_q) begin
                        state_d = S_WM_INIT;
                    end else begin
                        key_load = 1'b1;
                        state_d  = S_WK_INIT;
                    end
                end
            end
            S_WK_INIT: state_d = S_WK_DATA;
            S_WK_DATA: begin
                word_cnt_d = word_cnt_q + 2'd1;
                if (word_cnt_q == 2'd3) begin
                    key_loaded_d = 1'b1;
                    state_d      = S_WM_INIT;
                end
            end
            S_WM_INIT: state_d = S_WM_DATA;
            S_WM_DATA: begin
                word_cnt_d = word_cnt_q + 2'd1;
                if (word_cnt_q == 2'd3) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_W'(CIPHER_WAIT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_R_INIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            // With READ_LATENCY=1 the first word arrives right after the initiate cycle.
            S_R_INIT: state_d = (READ_LATENCY > 1) ? S_R_LAT : S_R_DATA;
            S_R_LAT: begin
                if (lat_cnt_q == LAT_W'(READ_LATENCY - 2)) begin
                    lat_cnt_d = '0;
                    state_d   = S_R_DATA;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_R_DATA: begin
                cap_d      = {cap_q[32:127], data};
                word_cnt_d = word_cnt_q + 2'd1;
                if (word_cnt_q == 2'd3) begin
                    result_d = cap_d;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from the state so an async reset releases the bus at once.
    assign data_oe       = (state_q == S_WK_DATA) || (state_q == S_WM_DATA);
    assign wr_word       = (state_q == S_WK_DATA) ? key_word : msg_word;
    assign data          = data_oe ? wr_word : 32'bz;
    assign data_oe_o     = data_oe;
    assign state_o       = state_q;

    assign host.initiate = (state_q == S_WK_INIT) || (state_q == S_WM_INIT) || (state_q == S_R_INIT);
    assign host.RW       = ((state_q == S_WK_INIT) || (state_q == S_WK_DATA) ||
                            (state_q == S_WM_INIT) || (state_q == S_WM_DATA)) ? RW_WRITE : RW_READ;
    assign host.adress   = ((state_q == S_WK_INIT) || (state_q == S_WK_DATA)) ? ADDR_KEY : ADDR_MSG;
    assign host.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign host.done     = (state_q == S_DONE);
    assign host.result   = result_q;

endmodule

// File: tb/tb_aes_host_bridge.sv
// Directed bench for aes_host_bridge: table of runs plus reset/ignored-start sequences.
module tb_aes_host_bridge;
    import aes_bridge_pkg::*;

    localparam int CIPHER_WAIT  = 12;
    localparam int READ_LATENCY = 2;
    localparam int LAT_FULL     = 5 + 5 + CIPHER_WAIT + 1 + READ_LATENCY + 4;
    localparam int LAT_REUSE    = LAT_FULL - 5;

    typedef struct {
        logic   reuse;
        block_t key;
        block_t msg;
        block_t ct;
        int     exp_lat;
        logic   exp_key;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    wire  [0:31] data;
    state_t      state_o;
    logic        data_oe_o;
    logic        tb_oe = 1'b0;
    word_t       tb_word = '0;
    block_t      cur_ct = '0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          unexp = 0;
    int          own_err = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [1:0]  exp_init_q[$];
    logic [32:0] exp_q[$];

    aes_host_bridge_if host();

    aes_host_bridge #(
        .CIPHER_WAIT  (CIPHER_WAIT),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (host.master),
        .data      (data),
        .state_o   (state_o),
        .data_oe_o (data_oe_o)
    );

    assign data = tb_oe ? tb_word : 32'bz;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // bus monitor and scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (host.initiate) begin
                if (data_oe_o) own_err++;
                if (exp_init_q.size() == 0) begin
                    unexp++;
                end else begin
                    check("init_rw_addr", {host.RW, host.adress}, exp_init_q.pop_front());
                    if (host.RW == RW_READ) check("wait_gap", cyc - last_wr_cyc, CIPHER_WAIT + 1);
                end
            end
            if (data_oe_o) begin
                if (exp_q.size() == 0) unexp++;
                else check("wr_word", {host.adress, data}, exp_q.pop_front());
                last_wr_cyc = cyc;
                if (tb_oe) own_err++;
                if (state_o != S_WK_DATA && state_o != S_WM_DATA) own_err++;
            end
        end
    end

    // AES-side read responder
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && host.initiate && host.RW == RW_READ) begin
                repeat (READ_LATENCY) @(posedge clk);
                for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                    #1;
                    tb_oe   = 1'b1;
                    tb_word = cur_ct[k*32 +: 32];
                    @(posedge clk);
                end
                #1 tb_oe = 1'b0;
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit poke);
        int     c0;
        int     n;
        int     busy_hi;
        int     err0;
        bit     poked;
        block_t kb;
        block_t mb;
        kb     = v.key;
        mb     = v.msg;
        cur_ct = v.ct;
        if (v.exp_key) begin
            exp_init_q.push_back({RW_WRITE, ADDR_KEY});
            for (int k = 0; k < 4; k++) exp_q.push_back({ADDR_KEY, kb[k*32 +: 32]});
        end
        exp_init_q.push_back({RW_WRITE, ADDR_MSG});
        for (int k = 0; k < 4; k++) exp_q.push_back({ADDR_MSG, mb[k*32 +: 32]});
        exp_init_q.push_back({RW_READ, ADDR_MSG});
        err0 = unexp + own_err;

        @(negedge clk);
        host.start     = 1'b1;
        host.reuse_key = v.reuse;
        host.key_in    = v.key;
        host.msg_in    = v.msg;
        c0 = cyc;
        @(negedge clk);
        host.start  = 1'b0;
        host.key_in = ~v.key;
        host.msg_in = ~v.msg;
        check("busy_after_start", host.busy, 1'b1);

        n = 0;
        poked = 1'b0;
        while (!host.done && n < 80) begin
            @(negedge clk);
            n++;
            if (host.start) begin
                host.start = 1'b0;
            end else if (poke && !poked && state_o == S_WAIT) begin
                host.start = 1'b1;
                poked = 1'b1;
            end
        end
        check("done_seen", host.done, 1'b1);
        check("done_latency", cyc - c0, v.exp_lat);
        check("result", host.result, v.ct);
        check("busy_in_done", host.busy, 1'b0);
        if (poke) host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        check("done_one_cycle", host.done, 1'b0);
        check("idle_after_done", state_o, S_IDLE);
        if (poke) begin
            busy_hi = 0;
            repeat (8) begin
                @(negedge clk);
                if (host.busy || state_o != S_IDLE) busy_hi++;
            end
            check("ignored_start_stays_idle", busy_hi, 0);
        end
        check("queues_drained", exp_init_q.size() + exp_q.size(), 0);
        check("bus_protocol_errors", unexp + own_err - err0, 0);
    endtask

    vec_t vecs[4];

    initial begin
        bit   found;
        vec_t v;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   found;
        vec_t v;
        vecs[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, LAT_FULL, 1'b1};
        vecs[1] = '{1'b1, 128'hffffffffffffffffffffffffffffffff, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h0123456789abcdeffedcba9876543210, LAT_REUSE, 1'b0};
        vecs[2] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, LAT_FULL, 1'b1};
        vecs[3] = '{1'b1, 128'h11111111222222223333333344444444, 128'ha5a5a5a55a5a5a5a00000000ffffffff,
                    128'hdeadbeefcafef00d123456789abcdef0, LAT_REUSE, 1'b0};

        host.start     = 1'b0;
        host.reuse_key = 1'b0;
        host.key_in    = '0;
        host.msg_in    = '0;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_initiate", host.initiate, 1'b0);
        check("rst_rw", host.RW, 1'b0);
        check("rst_adress", host.adress, 1'b0);
        check("rst_data_oe", data_oe_o, 1'b0);
        check("rst_busy_done", {host.busy, host.done}, 2'b00);
        check("rst_result", host.result, 128'h0);
        check("rst_state", state_o, S_IDLE);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

        // starts during WAIT and in the DONE cycle are both ignored
        v = '{1'b1, 128'h0, 128'h0f0e0d0c0b0a09080706050403020100,
              128'hcafebabe0badf00d5555aaaa12121212, LAT_REUSE, 1'b0};
        run_vec(v, 1'b1);

        // reset while the message word 2 is on the bus
        exp_init_q.push_back({RW_WRITE, ADDR_KEY});
        for (int k = 0; k < 4; k++) exp_q.push_back({ADDR_KEY, vecs[2].key[k*32 +: 32]});
        exp_init_q.push_back({RW_WRITE, ADDR_MSG});
        for (int k = 0; k < 4; k++) exp_q.push_back({ADDR_MSG, vecs[2].msg[k*32 +: 32]});
        @(negedge clk);
        host.start     = 1'b1;
        host.reuse_key = 1'b0;
        host.key_in    = vecs[2].key;
        host.msg_in    = vecs[2].msg;
        @(negedge clk);
        host.start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (state_o == S_WM_DATA && data == 32'h313198a2) found = 1'b1;
        end
        check("reached_wm_word2", found, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_data_oe", data_oe_o, 1'b0);
        check("async_rst_initiate", host.initiate, 1'b0);
        check("async_rst_busy", host.busy, 1'b0);
        check("async_rst_result", host.result, 128'h0);
        check("async_rst_state", state_o, S_IDLE);
        exp_init_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reuse_key right after reset must still write the key
        v = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, LAT_FULL, 1'b1};
        run_vec(v, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
